// File: rtl/altera_tse_gxb_aligned_txsync_pkg.sv
// Shared definitions for the GXB TX sync alignment stage: code-group
// constants, state encoding, the symbol bundle and the family latency groups.
package altera_tse_gxb_aligned_txsync_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D16_2 = 8'h50;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } txsync_state_e;

  // One transmit symbol as presented to the GXB transmitter.
  typedef struct packed {
    logic [7:0] data;
    logic       ctrl;
    logic       forcedisp;
    logic       dispval;
  } gxb_sym_t;

  // Value of the output stage while in reset: K28.5, neutral disparity.
  localparam gxb_sym_t RESET_SYM = '{data: K28_5, ctrl: 1'b1, forcedisp: 1'b0, dispval: 1'b0};

  // Families whose transceiver interface needs one extra output register.
  function automatic bit family_has_extra_stage(input string family);
    return (family == "STRATIXIV")   ||
           (family == "ARRIAIIGX")   ||
           (family == "CYCLONEIVGX") ||
           (family == "HARDCOPYIV")  ||
           (family == "ARRIAIIGZ");
  endfunction

endpackage

// File: rtl/altera_tse_gxb_aligned_txsync_idle_gen.sv
// Local /I2/ ordered-set generator: a free-running phase bit selecting
// K28.5 (phase 0) or D16.2 (phase 1). The phase is exported so the parent
// can judge ordered-set alignment of the PCS stream.
module altera_tse_txsync_idle_gen
  import altera_tse_gxb_aligned_txsync_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  output logic     phase,
  output gxb_sym_t idle_sym
);

  logic phase_q;
  logic phase_d;

  // Phase advances every clock, independent of the parent state.
  always_comb begin
    phase_d = ~phase_q;
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Idle symbol for the current phase; generated idles never force disparity.
  always_comb begin
    idle_sym.data      = phase_q ? D16_2 : K28_5;
    idle_sym.ctrl      = ~phase_q;
    idle_sym.forcedisp = 1'b0;
    idle_sym.dispval   = 1'b0;
  end

  assign phase = phase_q;

endmodule

// File: rtl/altera_tse_gxb_aligned_txsync.sv
// TX sync alignment stage between the 1000BASE-X PCS encoder and the GXB
// transmitter. Sources /I2/ idles until the transceiver is ready and the
// PCS stream presents K28.5 on an even ordered-set boundary, then passes
// PCS symbols through. Odd-position K28.5 in RUN is counted, not resynced.
module altera_tse_gxb_aligned_txsync
  import altera_tse_gxb_aligned_txsync_pkg::*;
#(
  parameter string       DEVICE_FAMILY = "ARRIAGX",
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned ALIGN_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] altpcs_datain,
  input  logic       altpcs_ctrlenable,
  input  logic       altpcs_forcedisp,
  input  logic       altpcs_dispval,
  input  logic       tx_ready,
  output logic [7:0] alt_datain,
  output logic       alt_ctrlenable,
  output logic       alt_forcedisp,
  output logic       alt_dispval,
  output logic       tx_sync,
  output logic       tx_align_err,
  output logic [7:0] tx_misalign_cnt
);

  localparam bit         EXTRA_STAGE  = family_has_extra_stage(DEVICE_FAMILY);
  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(ALIGN_TIMEOUT - 1);

  logic          rdy_meta_q;
  logic          rdy_s_q;
  gxb_sym_t      reg1_q;
  gxb_sym_t      pcs_sym;
  txsync_state_e state_q,        state_d;
  logic [7:0]    settle_cnt_q,   settle_cnt_d;
  logic [7:0]    timeout_cnt_q,  timeout_cnt_d;
  logic          align_err_q,    align_err_d;
  logic [7:0]    misalign_cnt_q, misalign_cnt_d;
  gxb_sym_t      out_q,          out_d;
  logic          sync_q,         sync_d;
  logic          pcs_is_k285;
  logic          phase;
  gxb_sym_t      idle_sym;
  gxb_sym_t      final_sym;
  logic          final_sync;

  altera_tse_txsync_idle_gen u_idle_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .phase    (phase),
    .idle_sym (idle_sym)
  );

  assign pcs_sym = '{data: altpcs_datain, ctrl: altpcs_ctrlenable,
                     forcedisp: altpcs_forcedisp, dispval: altpcs_dispval};

  assign pcs_is_k285 = reg1_q.ctrl && (reg1_q.data == K28_5);

  // Two-flop synchroniser for tx_ready and the single PCS input register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      reg1_q     <= '0;
    end else begin
      rdy_meta_q <= tx_ready;
      rdy_s_q    <= rdy_meta_q;
      reg1_q     <= pcs_sym;
    end
  end

  // Next-state, counters and output selection. The output register follows
  // the next state so the first PCS symbol leaves on the handover cycle and
  // idles resume on the cycle INIT is entered.
  always_comb begin
    state_d        = state_q;
    settle_cnt_d   = settle_cnt_q;
    timeout_cnt_d  = timeout_cnt_q;
    align_err_d    = align_err_q;
    misalign_cnt_d = misalign_cnt_q;

    if ((state_q == ST_RUN) && pcs_is_k285 && phase && (misalign_cnt_q != 8'hFF)) begin
      misalign_cnt_d = misalign_cnt_q + 8'd1;
    end

    if (!rdy_s_q) begin
      state_d       = ST_INIT;
      settle_cnt_d  = '0;
      timeout_cnt_d = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d       = ST_ALIGN;
            settle_cnt_d  = '0;
            timeout_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
        ST_ALIGN: begin
          if (pcs_is_k285 && !phase) begin
            state_d       = ST_RUN;
            timeout_cnt_d = '0;
          end else if (timeout_cnt_q == TIMEOUT_LAST) begin
            align_err_d   = 1'b1;
            timeout_cnt_d = '0;
          end else begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end

    sync_d = (state_d == ST_RUN);
    out_d  = sync_d ? reg1_q : idle_sym;
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_INIT;
      settle_cnt_q   <= '0;
      timeout_cnt_q  <= '0;
      align_err_q    <= 1'b0;
      misalign_cnt_q <= '0;
      out_q          <= RESET_SYM;
      sync_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      timeout_cnt_q  <= timeout_cnt_d;
      align_err_q    <= align_err_d;
      misalign_cnt_q <= misalign_cnt_d;
      out_q          <= out_d;
      sync_q         <= sync_d;
    end
  end

  generate
    if (EXTRA_STAGE) begin : g_extra_stage
      gxb_sym_t out_dly_q,  out_dly_d;
      logic     sync_dly_q, sync_dly_d;

      // Extra retiming stage; tx_sync is delayed with the data.
      always_comb begin
        out_dly_d  = out_q;
        sync_dly_d = sync_q;
      end

      // Extra output register.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_dly_q  <= RESET_SYM;
          sync_dly_q <= 1'b0;
        end else begin
          out_dly_q  <= out_dly_d;
          sync_dly_q <= sync_dly_d;
        end
      end

      assign final_sym  = out_dly_q;
      assign final_sync = sync_dly_q;
    end else begin : g_direct
      assign final_sym  = out_q;
      assign final_sync = sync_q;
    end
  endgenerate

  assign alt_datain      = final_sym.data;
  assign alt_ctrlenable  = final_sym.ctrl;
  assign alt_forcedisp   = final_sym.forcedisp;
  assign alt_dispval     = final_sym.dispval;
  assign tx_sync         = final_sync;
  assign tx_align_err    = align_err_q;
  assign tx_misalign_cnt = misalign_cnt_q;

endmodule

// File: tb/tb_altera_tse_gxb_aligned_txsync.sv
// Bench for the GXB TX sync stage: one 2-cycle (ARRIAGX) and one 3-cycle
// (STRATIXIV) instance share stimulus and are compared every cycle against
// a behavioural model, plus a latency vector table and directed corner cases.
module tb_altera_tse_gxb_aligned_txsync;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pcs_data;
  logic       pcs_ctrl, pcs_fd, pcs_dv;
  logic       tx_ready;

  logic [7:0] a_data, s_data, a_mcnt, s_mcnt;
  logic       a_ctrl, a_fd, a_dv, a_sync, a_err;
  logic       s_ctrl, s_fd, s_dv, s_sync, s_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  altera_tse_gxb_aligned_txsync #(.DEVICE_FAMILY("ARRIAGX")) dut_a (
    .clk(clk), .reset_n(reset_n),
    .altpcs_datain(pcs_data), .altpcs_ctrlenable(pcs_ctrl),
    .altpcs_forcedisp(pcs_fd), .altpcs_dispval(pcs_dv), .tx_ready(tx_ready),
    .alt_datain(a_data), .alt_ctrlenable(a_ctrl), .alt_forcedisp(a_fd),
    .alt_dispval(a_dv), .tx_sync(a_sync), .tx_align_err(a_err),
    .tx_misalign_cnt(a_mcnt));

  altera_tse_gxb_aligned_txsync #(.DEVICE_FAMILY("STRATIXIV")) dut_s (
    .clk(clk), .reset_n(reset_n),
    .altpcs_datain(pcs_data), .altpcs_ctrlenable(pcs_ctrl),
    .altpcs_forcedisp(pcs_fd), .altpcs_dispval(pcs_dv), .tx_ready(tx_ready),
    .alt_datain(s_data), .alt_ctrlenable(s_ctrl), .alt_forcedisp(s_fd),
    .alt_dispval(s_dv), .tx_sync(s_sync), .tx_align_err(s_err),
    .tx_misalign_cnt(s_mcnt));

  // ---------------- behavioural model ----------------
  int unsigned k;            // clock edges since reset release
  bit          m_sync1, m_rdys;
  logic [10:0] m_r1;         // {data, ctrl, fd, dv} one cycle behind the input
  bit          in_run, in_align;
  int          streak, waited, m_mcnt;
  bit          m_err;
  logic [11:0] exp_a, exp_s; // {data, ctrl, fd, dv, sync}

  function automatic logic [10:0] idle_of(int unsigned cyc);
    return (cyc % 2 == 1) ? {8'h50, 3'b000} : {8'hBC, 3'b100};
  endfunction

  task automatic model_reset();
    k = 0; m_sync1 = 0; m_rdys = 0; m_r1 = '0;
    in_run = 0; in_align = 0; streak = 0; waited = 0; m_mcnt = 0; m_err = 0;
    exp_a = {8'hBC, 3'b100, 1'b0};
    exp_s = exp_a;
  endtask

  task automatic model_edge();
    bit k285, odd;
    k285 = (m_r1[10:3] == 8'hBC) && m_r1[2];
    odd  = (k % 2 == 1);
    if (in_run && k285 && odd && m_mcnt < 255) m_mcnt++;
    if (!m_rdys) begin
      in_run = 0; in_align = 0; streak = 0;
    end else if (in_run) begin
    end else if (in_align) begin
      if (k285 && !odd) begin
        in_run = 1; in_align = 0;
      end else begin
        waited++;
        if (waited % TIMEOUT == 0) m_err = 1;
      end
    end else begin
      streak++;
      if (streak == SETTLE) begin in_align = 1; waited = 0; streak = 0; end
    end
    exp_s = exp_a;
    exp_a = in_run ? {m_r1, 1'b1} : {idle_of(k), 1'b0};
    m_rdys  = m_sync1;
    m_sync1 = tx_ready;
    m_r1    = {pcs_data, pcs_ctrl, pcs_fd, pcs_dv};
    k++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cycle_arriagx",  {a_data, a_ctrl, a_fd, a_dv, a_sync, a_err, a_mcnt},
                            {exp_a, m_err, 8'(m_mcnt)});
    check("cycle_stratix4", {s_data, s_ctrl, s_fd, s_dv, s_sync, s_err, s_mcnt},
                            {exp_s, m_err, 8'(m_mcnt)});
  endtask

  // mode 0: K28.5 lands on phase 0; mode 1: K28.5 lands on phase 1; mode 2: all K28.5
  task automatic drive_stream(input int mode);
    bit bc;
    case (mode)
      0:       bc = (k % 2 == 1);
      1:       bc = (k % 2 == 0);
      default: bc = 1'b1;
    endcase
    pcs_data = bc ? 8'hBC : 8'h50;
    pcs_ctrl = bc;
    pcs_fd = 1'b0; pcs_dv = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0] d; logic c, f, v;
    logic [7:0] ed; logic ec, ef, ev;
  } vec_t;

  vec_t        tbl[6];
  logic [10:0] cap_a[10], cap_s[10];
  int          rise_a, rise_s;

  initial begin
    #1_000_000;
    $display("FAIL watchdog k=%0d got=timeout expected=finish", k);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'hD5, 1'b0, 1'b0, 1'b0, 8'hD5, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'hA7, 1'b0, 1'b0, 1'b1, 8'hA7, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'hF7, 1'b1, 1'b1, 1'b1, 8'hF7, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; tx_ready = 1'b1;
    model_reset();
    drive_stream(0);
    @(negedge clk); @(negedge clk);
    check("reset_a", {a_data, a_ctrl, a_fd, a_dv, a_sync, a_err, a_mcnt}, {8'hBC, 4'b1000, 1'b0, 8'h00});
    check("reset_s", {s_data, s_ctrl, s_fd, s_dv, s_sync, s_err, s_mcnt}, {8'hBC, 4'b1000, 1'b0, 8'h00});
    reset_n = 1'b1;

    // Bring-up with an aligned PCS idle stream.
    rise_a = -1; rise_s = -1;
    for (int i = 0; i < 40; i++) begin
      drive_stream(0);
      tick();
      if (rise_a < 0 && a_sync) rise_a = int'(k);
      if (rise_s < 0 && s_sync) rise_s = int'(k);
    end
    check("sync_rise_a", rise_a, 2 + SETTLE + 1);
    check("sync_rise_s", rise_s, 2 + SETTLE + 2);

    // Frame bytes through RUN: 2-cycle and 3-cycle latency.
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        pcs_data = tbl[i].d; pcs_ctrl = tbl[i].c; pcs_fd = tbl[i].f; pcs_dv = tbl[i].v;
      end else begin
        drive_stream(0);
      end
      tick();
      cap_a[i] = {a_data, a_ctrl, a_fd, a_dv};
      cap_s[i] = {s_data, s_ctrl, s_fd, s_dv};
    end
    for (int i = 0; i < 6; i++) begin
      check("lat2_arriagx",  cap_a[i + 1], {tbl[i].ed, tbl[i].ec, tbl[i].ef, tbl[i].ev});
      check("lat3_stratix4", cap_s[i + 2], {tbl[i].ed, tbl[i].ec, tbl[i].ef, tbl[i].ev});
    end

    // Single odd-position K28.5, then saturation.
    for (int i = 0; i < 4; i++) begin drive_stream(0); tick(); end
    if (k % 2 == 1) begin drive_stream(0); tick(); end
    drive_stream(1); tick();
    for (int i = 0; i < 4; i++) begin drive_stream(0); tick(); end
    check("misalign_one", {a_mcnt, a_sync}, {8'd1, 1'b1});
    for (int i = 0; i < 600; i++) begin drive_stream(2); tick(); end
    check("misalign_sat", {a_mcnt, s_mcnt, a_sync}, {8'd255, 8'd255, 1'b1});

    // One-cycle tx_ready drop: INIT two edges later.
    drive_stream(0); tx_ready = 1'b0; tick();
    drive_stream(0); tx_ready = 1'b1; tick();
    check("drop_sync_still", a_sync, 1'b1);
    drive_stream(0); tick();
    check("drop_sync_low", a_sync, 1'b0);

    // ALIGN with K28.5 only on phase 1: timeout, stays idle.
    for (int i = 0; i < 300; i++) begin drive_stream(1); tick(); end
    check("timeout_err", {a_err, a_sync, s_sync}, {1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 6; i++) begin drive_stream(0); tick(); end
    check("realign_keep", {a_sync, a_err, a_mcnt}, {1'b1, 1'b1, 8'd255});

    // Randomised traffic with occasional ready drops.
    for (int i = 0; i < 2500; i++) begin
      tx_ready = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 4) != 0) begin
        drive_stream(0);
        pcs_fd = 1'($urandom); pcs_dv = 1'($urandom);
      end else begin
        pcs_data = ($urandom_range(0, 1) != 0) ? 8'hBC : 8'($urandom);
        pcs_ctrl = 1'($urandom); pcs_fd = 1'($urandom); pcs_dv = 1'($urandom);
      end
      tick();
    end

    // Asynchronous reset mid-frame, no clock edge in between.
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin drive_stream(0); tick(); end
    pcs_data = 8'hD5; pcs_ctrl = 1'b0; pcs_fd = 1'b1; pcs_dv = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_a", {a_data, a_ctrl, a_fd, a_dv, a_sync, a_err, a_mcnt}, {8'hBC, 4'b1000, 1'b0, 8'h00});
    check("async_rst_s", {s_data, s_ctrl, s_fd, s_dv, s_sync, s_err, s_mcnt}, {8'hBC, 4'b1000, 1'b0, 8'h00});
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin drive_stream(0); tick(); end
    check("post_rst_sync", {a_sync, s_sync}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
